mem_stage: RTL and testbench

//  Receiving end of the EX stage outputs in the 5-stage MIPS pipeline: EX/MEM latch, data memory, byte-lane

---
 rtl/mem_stage_pkg.sv | 40 ++++
 rtl/mem_stage_dm.sv | 35 +++
 rtl/mem_stage.sv | 144 ++++++++++++++
 tb/tb_mem_stage.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: instruction codes, data-memory sizing,
// byte-lane masks and the store lane-merge helper.
package mem_stage_pkg;

    localparam int DM_ADDR_W_DEFAULT = 12;

    // Instruction codes carried down the pipeline (NOP must stay 0: reset value)
    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_LW   = 6'd1;
    localparam logic [5:0] OP_LH   = 6'd2;
    localparam logic [5:0] OP_LHU  = 6'd3;
    localparam logic [5:0] OP_LB   = 6'd4;
    localparam logic [5:0] OP_LBU  = 6'd5;
    localparam logic [5:0] OP_SW   = 6'd6;
    localparam logic [5:0] OP_SH   = 6'd7;
    localparam logic [5:0] OP_SB   = 6'd8;
    localparam logic [5:0] OP_ADDU = 6'd9;

    // Byte-lane write masks (lane 0 = bits [7:0], little-endian)
    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    // Word as it looks after a byte-enabled write of new_word over old_word
    function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_stage_dm.sv
// Data memory: word array with byte-enabled synchronous write, combinational
// read and a synchronous clear of every word on reset.
module mem_stage_dm #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] mem_r [DEPTH];

    // Clear on reset (reset beats a coincident store), otherwise write enabled lanes
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_r[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: EX/MEM latch, data memory access with
// byte-lane stores and extended loads, MEM/WB latch, forwarding tap to EX.
// Optional feature macro: MEM_DISPLAY_EN prints every committed store.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DM_ADDR_W = DM_ADDR_W_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] instructure_in,
    input  logic [5:0]  instr_code_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] reg_read_data2_in,
    output logic [31:0] forward_data_MEM,
    output logic [31:0] pc_out,
    output logic [31:0] instructure_out,
    output logic [5:0]  instr_code_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] mem_read_data_out
);

    logic [31:0]          exm_pc_r;
    logic [31:0]          exm_instr_r;
    logic [5:0]           exm_code_r;
    logic [31:0]          exm_alu_r;
    logic [31:0]          exm_rt_r;

    logic [DM_ADDR_W-1:0] word_addr_s;
    logic [3:0]           be_s;
    logic [31:0]          wdata_s;
    logic [31:0]          rd_word_s;
    logic [15:0]          half_s;
    logic [7:0]           byte_s;
    logic [31:0]          load_data_s;

    // EX/MEM latch: captures EX results every cycle, bubbles arrive as NOP
    always_ff @(posedge clk) begin
        if (reset) begin
            exm_pc_r    <= 32'd0;
            exm_instr_r <= 32'd0;
            exm_code_r  <= OP_NOP;
            exm_alu_r   <= 32'd0;
            exm_rt_r    <= 32'd0;
        end else begin
            exm_pc_r    <= pc_in;
            exm_instr_r <= instructure_in;
            exm_code_r  <= instr_code_in;
            exm_alu_r   <= alu_result_in;
            exm_rt_r    <= reg_read_data2_in;
        end
    end

    assign forward_data_MEM = exm_alu_r;
    // Upper address bits are dropped, so addresses wrap modulo memory size
    assign word_addr_s      = exm_alu_r[DM_ADDR_W+1:2];

    // Store lane selection; half-word stores ignore addr[0]
    always_comb begin
        be_s    = BE_NONE;
        wdata_s = 32'd0;
        case (exm_code_r)
            OP_SW: begin
                be_s    = BE_WORD;
                wdata_s = exm_rt_r;
            end
            OP_SH: begin
                be_s    = exm_alu_r[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata_s = {2{exm_rt_r[15:0]}};
            end
            OP_SB: begin
                be_s    = BE_BYTE0 << exm_alu_r[1:0];
                wdata_s = {4{exm_rt_r[7:0]}};
            end
            default: begin
                be_s    = BE_NONE;
                wdata_s = 32'd0;
            end
        endcase
    end

    mem_stage_dm #(
        .ADDR_W (DM_ADDR_W)
    ) u_dm (
        .clk   (clk),
        .reset (reset),
        .addr  (word_addr_s),
        .be    (be_s),
        .wdata (wdata_s),
        .rdata (rd_word_s)
    );

    // Load lane extraction and sign/zero extension; non-loads yield 0
    always_comb begin
        half_s      = exm_alu_r[1] ? rd_word_s[31:16] : rd_word_s[15:0];
        byte_s      = 8'd0;
        load_data_s = 32'd0;
        case (exm_alu_r[1:0])
            2'd0:    byte_s = rd_word_s[7:0];
            2'd1:    byte_s = rd_word_s[15:8];
            2'd2:    byte_s = rd_word_s[23:16];
            2'd3:    byte_s = rd_word_s[31:24];
            default: byte_s = 8'd0;
        endcase
        case (exm_code_r)
            OP_LW:   load_data_s = rd_word_s;
            OP_LH:   load_data_s = {{16{half_s[15]}}, half_s};
            OP_LHU:  load_data_s = {16'd0, half_s};
            OP_LB:   load_data_s = {{24{byte_s[7]}}, byte_s};
            OP_LBU:  load_data_s = {24'd0, byte_s};
            default: load_data_s = 32'd0;
        endcase
    end

    // MEM/WB latch: hands the stage result to WB one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out            <= 32'd0;
            instructure_out   <= 32'd0;
            instr_code_out    <= OP_NOP;
            alu_result_out    <= 32'd0;
            mem_read_data_out <= 32'd0;
        end else begin
            pc_out            <= exm_pc_r;
            instructure_out   <= exm_instr_r;
            instr_code_out    <= exm_code_r;
            alu_result_out    <= exm_alu_r;
            mem_read_data_out <= load_data_s;
        end
    end

`ifdef MEM_DISPLAY_EN
    // Trace each committed store with the full post-merge word
    always_ff @(posedge clk) begin
        if (!reset && (be_s != BE_NONE)) begin
            $display("%d@%h: *%h <= %h", $time, exm_pc_r,
                     {{(30-DM_ADDR_W){1'b0}}, word_addr_s, 2'b00},
                     merge_word(rd_word_s, wdata_s, be_s));
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected MEM/WB results,
// a negedge monitor pops and compares whenever a non-NOP reaches WB.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in, instructure_in, alu_result_in, reg_read_data2_in;
    logic [5:0]  instr_code_in;
    logic [31:0] forward_data_MEM, pc_out, instructure_out, alu_result_out, mem_read_data_out;
    logic [5:0]  instr_code_out;

    always #5 clk = ~clk;

    mem_stage #(.DM_ADDR_W(12)) dut (
        .clk               (clk),
        .reset             (reset),
        .pc_in             (pc_in),
        .instructure_in    (instructure_in),
        .instr_code_in     (instr_code_in),
        .alu_result_in     (alu_result_in),
        .reg_read_data2_in (reg_read_data2_in),
        .forward_data_MEM  (forward_data_MEM),
        .pc_out            (pc_out),
        .instructure_out   (instructure_out),
        .instr_code_out    (instr_code_out),
        .alu_result_out    (alu_result_out),
        .mem_read_data_out (mem_read_data_out)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [5:0]  code;
        logic [31:0] alu;
        logic [31:0] mrd;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          sb_en = 1'b0;
    logic [31:0] prev_fwd = 32'd0;
    logic [31:0] pc_cnt = 32'h0040_0000;
    localparam logic [31:0] JUNK = 32'hFFFF_FFFF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare WB outputs against the oldest expected entry
    always @(negedge clk) begin
        if (sb_en && instr_code_out != OP_NOP) begin
            if (q.size() == 0) begin
                chk("unexpected_output", {26'd0, instr_code_out}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("pc_out", pc_out, e.pc);
                chk("instructure_out", instructure_out, e.instr);
                chk("instr_code_out", {26'd0, instr_code_out}, {26'd0, e.code});
                chk("alu_result_out", alu_result_out, e.alu);
                chk("mem_read_data_out", mem_read_data_out, e.mrd);
                chk("forward_data_MEM", prev_fwd, e.alu);
            end
        end
        prev_fwd = forward_data_MEM;
    end

    task automatic issue(input logic [5:0] code, input logic [31:0] alu,
                         input logic [31:0] rt, input logic [31:0] mrd, input bit push);
        @(negedge clk);
        pc_in             = pc_cnt;
        instructure_in    = 32'hA500_0000 ^ pc_cnt;
        instr_code_in     = code;
        alu_result_in     = alu;
        reg_read_data2_in = rt;
        if (push && code != OP_NOP) begin
            q.push_back('{pc: pc_cnt, instr: 32'hA500_0000 ^ pc_cnt, code: code, alu: alu, mrd: mrd});
        end
        pc_cnt = pc_cnt + 32'd4;
    endtask

    task automatic idle_inputs();
        pc_in             = 32'd0;
        instructure_in    = 32'd0;
        instr_code_in     = OP_NOP;
        alu_result_in     = 32'd0;
        reg_read_data2_in = 32'd0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pc"}, pc_out, 32'd0);
        chk({tag, "_instr"}, instructure_out, 32'd0);
        chk({tag, "_code"}, {26'd0, instr_code_out}, 32'd0);
        chk({tag, "_alu"}, alu_result_out, 32'd0);
        chk({tag, "_mrd"}, mem_read_data_out, 32'd0);
        chk({tag, "_fwd"}, forward_data_MEM, 32'd0);
    endtask

    initial begin
        logic [5:0] rcodes [5];
        rcodes[0] = OP_SW; rcodes[1] = OP_SH; rcodes[2] = OP_SB;
        rcodes[3] = OP_ADDU; rcodes[4] = OP_LW;

        reset = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        check_all_zero("init_reset");
        reset = 1'b0;

        // Unchecked random traffic to dirty memory and pipeline
        for (int i = 0; i < 20; i++) begin
            issue(rcodes[$urandom_range(0, 4)], {20'd0, 10'($urandom_range(0, 1023)), 2'b00},
                  $urandom, 32'd0, 1'b0);
        end
        issue(OP_SW, 32'h0000_0200, 32'hFFFF_FFFF, 32'd0, 1'b0);

        // Reset arrives on the edge that would commit the store above
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        sb_en = 1'b1;

        // Memory is all zero now
        issue(OP_LW,   32'h0000_0200, JUNK, 32'h0000_0000, 1'b1);
        issue(OP_LW,   32'h0000_01C4, JUNK, 32'h0000_0000, 1'b1);
        issue(OP_SB,   32'h0000_0013, 32'h1234_56AB, 32'd0, 1'b1);
        issue(OP_LW,   32'h0000_0010, JUNK, 32'hAB00_0000, 1'b1);
        issue(OP_LB,   32'h0000_0013, JUNK, 32'hFFFF_FFAB, 1'b1);
        issue(OP_LBU,  32'h0000_0013, JUNK, 32'h0000_00AB, 1'b1);
        issue(OP_LB,   32'h0000_0012, JUNK, 32'h0000_0000, 1'b1);
        issue(OP_SW,   32'h0000_0010, 32'h1234_5678, 32'd0, 1'b1);
        issue(OP_LW,   32'h0000_0010, JUNK, 32'h1234_5678, 1'b1);
        issue(OP_LB,   32'h0000_0010, JUNK, 32'h0000_0078, 1'b1);
        issue(OP_LB,   32'h0000_0011, JUNK, 32'h0000_0056, 1'b1);
        issue(OP_LH,   32'h0000_0012, JUNK, 32'h0000_1234, 1'b1);
        issue(OP_LHU,  32'h0000_0010, JUNK, 32'h0000_5678, 1'b1);
        issue(OP_SH,   32'h0000_0022, 32'hCAFE_8001, 32'd0, 1'b1);
        issue(OP_LW,   32'h0000_0020, JUNK, 32'h8001_0000, 1'b1);
        issue(OP_LH,   32'h0000_0022, JUNK, 32'hFFFF_8001, 1'b1);
        issue(OP_LHU,  32'h0000_0022, JUNK, 32'h0000_8001, 1'b1);
        issue(OP_LH,   32'h0000_0023, JUNK, 32'hFFFF_8001, 1'b1);
        issue(OP_LH,   32'h0000_0020, JUNK, 32'h0000_0000, 1'b1);
        issue(OP_ADDU, 32'h0000_0055, JUNK, 32'h0000_0000, 1'b1);
        issue(OP_LW,   32'h0000_0054, JUNK, 32'h0000_0000, 1'b1);
        issue(OP_SW,   32'h0000_4000, 32'hDEAD_BEEF, 32'd0, 1'b1);
        issue(OP_LW,   32'h0000_0000, JUNK, 32'hDEAD_BEEF, 1'b1);
        issue(OP_LW,   32'h0000_4000, JUNK, 32'hDEAD_BEEF, 1'b1);
        issue(OP_LB,   32'h0000_0003, JUNK, 32'hFFFF_FFDE, 1'b1);
        issue(OP_LB,   32'h0000_0001, JUNK, 32'hFFFF_FFBE, 1'b1);
        issue(OP_LHU,  32'h0000_0002, JUNK, 32'h0000_DEAD, 1'b1);
        issue(OP_SH,   32'h0000_0021, 32'h1234_BEEF, 32'd0, 1'b1);
        issue(OP_LW,   32'h0000_0020, JUNK, 32'h8001_BEEF, 1'b1);
        issue(OP_SB,   32'h0000_0021, 32'h0000_0077, 32'd0, 1'b1);
        issue(OP_LBU,  32'h0000_0021, JUNK, 32'h0000_0077, 1'b1);
        issue(OP_LW,   32'h0000_0020, JUNK, 32'h8001_77EF, 1'b1);
        issue(OP_SW,   32'h0000_0013, 32'h0000_0000, 32'd0, 1'b1);
        issue(OP_NOP,  32'h0000_0000, 32'd0, 32'd0, 1'b1);
        issue(OP_LW,   32'h0000_0010, JUNK, 32'h0000_0000, 1'b1);

        // Drain the pipeline, then every expected entry must have been seen
        for (int i = 0; i < 4; i++) begin
            issue(OP_NOP, 32'd0, 32'd0, 32'd0, 1'b0);
        end
        @(negedge clk);
        chk("queue_drain", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
